// File: rtl/mem_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_if
// Description : Execute->memory->write-back pipeline bundle plus the data
//               SRAM req/addr_ok/data_ok bus seen by the memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_if;
    logic        exe_to_mem_valid;
    logic        mem_allowin;
    logic [31:0] exe_pc;
    logic [31:0] exe_result;
    logic        exe_res_from_mem;
    logic [7:0]  exe_mem_all;
    logic [31:0] exe_rkd_value;
    logic [5:0]  exe_rf_all;

    logic        data_sram_req;
    logic        data_sram_wr;
    logic [1:0]  data_sram_size;
    logic [3:0]  data_sram_wstrb;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic        data_sram_addr_ok;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;

    logic        wb_allowin;
    logic        mem_to_wb_valid;
    logic [31:0] mem_pc;
    logic [31:0] mem_result;
    logic [5:0]  mem_rf_all;
    logic [38:0] mem_fwd_all;

    // master: the memory stage itself
    modport master (
        input  exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem,
               exe_mem_all, exe_rkd_value, exe_rf_all,
               data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
               wb_allowin,
        output mem_allowin,
               data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
               mem_to_wb_valid, mem_pc, mem_result, mem_rf_all, mem_fwd_all
    );

    // slave: surrounding pipeline and data SRAM
    modport slave (
        output exe_to_mem_valid, exe_pc, exe_result, exe_res_from_mem,
               exe_mem_all, exe_rkd_value, exe_rf_all,
               data_sram_addr_ok, data_sram_data_ok, data_sram_rdata,
               wb_allowin,
        input  mem_allowin,
               data_sram_req, data_sram_wr, data_sram_size, data_sram_wstrb,
               data_sram_addr, data_sram_wdata,
               mem_to_wb_valid, mem_pc, mem_result, mem_rf_all, mem_fwd_all
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : Memory-access pipeline stage: one data-SRAM request per memory
//               instruction, store lane alignment, load extraction/extension.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    mem_stage_if.master bus
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_WAIT = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    logic        valid_q, valid_d;
    logic [1:0]  state_q, state_d;
    logic [5:0]  rf_all_q, rf_all_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] result_q, result_d;
    logic        res_from_mem_q, res_from_mem_d;
    logic [7:0]  mem_all_q, mem_all_d;
    logic [31:0] rkd_q, rkd_d;

    logic        w_ready_go, w_allowin, w_latch, w_leave, w_in_is_mem;
    logic        w_mem_we, w_ld_b, w_ld_h, w_ld_w, w_ld_se, w_st_b, w_st_h, w_st_w;
    logic [1:0]  w_a;
    logic [31:0] w_rdata, w_shift, w_load, w_mem_result;
    logic [15:0] w_half;
    logic [7:0]  w_byte;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [1:0]  w_size;

    assign {w_mem_we, w_ld_b, w_ld_h, w_ld_w, w_ld_se, w_st_b, w_st_h, w_st_w} = mem_all_q;
    assign w_a = result_q[1:0];

    always_comb begin
        w_ready_go  = (state_q == c_IDLE) || (state_q == c_DONE) ||
                      ((state_q == c_WAIT) && bus.data_sram_data_ok);
        w_allowin   = !valid_q || (w_ready_go && bus.wb_allowin);
        w_latch     = bus.exe_to_mem_valid && w_allowin;
        w_leave     = valid_q && w_ready_go && bus.wb_allowin;
        w_in_is_mem = bus.exe_mem_all[7] || bus.exe_res_from_mem;
    end

    always_comb begin
        valid_d        = w_allowin ? bus.exe_to_mem_valid : valid_q;
        pc_d           = pc_q;
        result_d       = result_q;
        res_from_mem_d = res_from_mem_q;
        mem_all_d      = mem_all_q;
        rkd_d          = rkd_q;
        rf_all_d       = rf_all_q;
        rdata_buf_d    = rdata_buf_q;
        state_d        = state_q;

        if (w_latch) begin
            pc_d           = bus.exe_pc;
            result_d       = bus.exe_result;
            res_from_mem_d = bus.exe_res_from_mem;
            mem_all_d      = bus.exe_mem_all;
            rkd_d          = bus.exe_rkd_value;
            rf_all_d       = bus.exe_rf_all;
        end

        if ((state_q == c_WAIT) && bus.data_sram_data_ok) begin
            rdata_buf_d = bus.data_sram_rdata;
        end

        // A new latch wins even when the old instruction leaves on the same edge.
        if (w_latch) begin
            state_d = w_in_is_mem ? c_REQ : c_IDLE;
        end else if (w_leave) begin
            state_d = c_IDLE;
        end else begin
            case (state_q)
                c_REQ:   if (bus.data_sram_addr_ok) state_d = c_WAIT;
                c_WAIT:  if (bus.data_sram_data_ok) state_d = c_DONE;
                default: state_d = state_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q     <= 1'b0;
            state_q     <= c_IDLE;
            rf_all_q    <= 6'd0;
            rdata_buf_q <= 32'd0;
        end else begin
            valid_q     <= valid_d;
            state_q     <= state_d;
            rf_all_q    <= rf_all_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    always_ff @(posedge clk) begin
        pc_q           <= pc_d;
        result_q       <= result_d;
        res_from_mem_q <= res_from_mem_d;
        mem_all_q      <= mem_all_d;
        rkd_q          <= rkd_d;
    end

    always_comb begin
        w_size = (w_st_b || w_ld_b) ? 2'd0 : ((w_st_h || w_ld_h) ? 2'd1 : 2'd2);

        w_wstrb = 4'b0000;
        if (w_mem_we) begin
            if (w_st_w)      w_wstrb = 4'b1111;
            else if (w_st_h) w_wstrb = 4'b0011 << {w_a[1], 1'b0};
            else if (w_st_b) w_wstrb = 4'b0001 << w_a;
        end

        if (w_st_b)      w_wdata = {4{rkd_q[7:0]}};
        else if (w_st_h) w_wdata = {2{rkd_q[15:0]}};
        else             w_wdata = rkd_q;

        // Bypass the buffer in the data_ok cycle so a load costs no extra bubble.
        w_rdata = (state_q == c_DONE) ? rdata_buf_q : bus.data_sram_rdata;
        w_shift = w_rdata >> {w_a, 3'b000};
        w_byte  = w_shift[7:0];
        w_half  = w_a[1] ? w_rdata[31:16] : w_rdata[15:0];

        if (w_ld_w)      w_load = w_rdata;
        else if (w_ld_h) w_load = w_ld_se ? {{16{w_half[15]}}, w_half} : {16'd0, w_half};
        else             w_load = w_ld_se ? {{24{w_byte[7]}}, w_byte} : {24'd0, w_byte};

        w_mem_result = res_from_mem_q ? w_load : result_q;
    end

    assign bus.mem_allowin     = w_allowin;
    assign bus.data_sram_req   = valid_q && (state_q == c_REQ);
    assign bus.data_sram_wr    = w_mem_we;
    assign bus.data_sram_size  = w_size;
    assign bus.data_sram_wstrb = w_wstrb;
    assign bus.data_sram_addr  = result_q;
    assign bus.data_sram_wdata = w_wdata;
    assign bus.mem_to_wb_valid = valid_q && w_ready_go;
    assign bus.mem_pc          = pc_q;
    assign bus.mem_result      = w_mem_result;
    assign bus.mem_rf_all      = {rf_all_q[5] & valid_q, rf_all_q[4:0]};
    assign bus.mem_fwd_all     = {valid_q & res_from_mem_q & ~w_ready_go,
                                  rf_all_q[5] & valid_q, rf_all_q[4:0], w_mem_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with a byte-level memory model
//               and a latency-randomised data SRAM responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    localparam int K_ALU = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4,
                   K_LW = 5, K_SB = 6, K_SH = 7, K_SW = 8;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] result;
        logic [5:0]  rf_all;
    } wb_t;

    typedef struct {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_stage_if bus ();
    mem_stage dut (.clk(clk), .reset(reset), .bus(bus));

    wb_t  exp_wb[$];
    req_t exp_req[$];
    logic [7:0]  ref_bytes[64];
    logic [31:0] sram_mem[16];

    int     checks = 0;
    int     errors = 0;
    longint cyc = 0;
    longint last_leave = 0;
    longint req_gap = 0;
    int     dok_count = 0;
    int     cfg_aok_lat = -1;
    int     cfg_dok_lat = -1;
    int     wb_mode = 1;
    bit     pending = 1'b0;
    int     lat = 0;
    int     req_wait = 0;
    int     need_wait = 0;
    logic [31:0] rd_word = 32'd0;
    wb_t    mon_e;
    req_t   mon_r;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] mem_bits(input int k);
        logic [7:0] m;
        m[7] = (k == K_SB) || (k == K_SH) || (k == K_SW);
        m[6] = (k == K_LB) || (k == K_LBU);
        m[5] = (k == K_LH) || (k == K_LHU);
        m[4] = (k == K_LW);
        m[3] = (k == K_LB) || (k == K_LH);
        m[2] = (k == K_SB);
        m[1] = (k == K_SH);
        m[0] = (k == K_SW);
        return m;
    endfunction

    // Offer one instruction until accepted; expectations are formed at acceptance.
    task automatic issue(input int k, input logic [31:0] res, input logic [31:0] rkd,
                         input logic [31:0] pc, input logic rf_we, input logic [4:0] waddr);
        wb_t  e;
        req_t r;
        int   b;
        bit   ok;
        logic [7:0] v8;
        logic [15:0] v16;
        bus.exe_to_mem_valid = 1'b1;
        bus.exe_pc           = pc;
        bus.exe_result       = res;
        bus.exe_res_from_mem = (k >= K_LB) && (k <= K_LW);
        bus.exe_mem_all      = mem_bits(k);
        bus.exe_rkd_value    = rkd;
        bus.exe_rf_all       = {rf_we, waddr};
        ok = 1'b0;
        for (int n = 0; n < 300 && !ok; n++) begin
            @(negedge clk);
            if (bus.mem_allowin) ok = 1'b1;
        end
        if (!ok) begin
            check("issue_timeout", 64'd0, 64'd1);
        end else begin
            b = int'(res[5:0]);
            e.pc = pc;
            e.rf_all = {rf_we, waddr};
            e.result = res;
            r.wr = 1'b0; r.addr = res; r.wstrb = 4'b0000; r.wdata = rkd;
            r.size = 2'd2;
            case (k)
                K_LB, K_LBU: begin
                    v8 = ref_bytes[b];
                    e.result = (k == K_LB) ? {{24{v8[7]}}, v8} : {24'd0, v8};
                    r.size = 2'd0;
                end
                K_LH, K_LHU: begin
                    v16 = {ref_bytes[b+1], ref_bytes[b]};
                    e.result = (k == K_LH) ? {{16{v16[15]}}, v16} : {16'd0, v16};
                    r.size = 2'd1;
                end
                K_LW: e.result = {ref_bytes[b+3], ref_bytes[b+2], ref_bytes[b+1], ref_bytes[b]};
                K_SB: begin
                    ref_bytes[b] = rkd[7:0];
                    r.wr = 1'b1; r.size = 2'd0; r.wstrb[b%4] = 1'b1;
                    r.wdata = {4{rkd[7:0]}};
                end
                K_SH: begin
                    ref_bytes[b] = rkd[7:0]; ref_bytes[b+1] = rkd[15:8];
                    r.wr = 1'b1; r.size = 2'd1;
                    r.wstrb[b%4] = 1'b1; r.wstrb[(b+1)%4] = 1'b1;
                    r.wdata = {2{rkd[15:0]}};
                end
                K_SW: begin
                    for (int i = 0; i < 4; i++) ref_bytes[b+i] = rkd[8*i +: 8];
                    r.wr = 1'b1; r.wstrb = 4'b1111;
                end
                default: ;
            endcase
            exp_wb.push_back(e);
            if (k != K_ALU) exp_req.push_back(r);
        end
        @(posedge clk); #1;
        bus.exe_to_mem_valid = 1'b0;
        bus.exe_result       = $urandom;
        bus.exe_rkd_value    = $urandom;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 1000 && exp_wb.size() != 0; n++) @(negedge clk);
        check("drain_timeout", 64'(exp_wb.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    // Monitor (write-back side) and SRAM observer share one block to fix ordering.
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            pending  = 1'b0;
            req_wait = 0;
        end else begin
            if ((pending && !bus.data_sram_data_ok) || bus.data_sram_req)
                check("early_ready_go", 64'(bus.mem_to_wb_valid), 64'd0);
            if (bus.mem_to_wb_valid && bus.wb_allowin) begin
                if (exp_wb.size() == 0) begin
                    check("unexpected_wb", 64'd1, 64'd0);
                end else begin
                    mon_e = exp_wb.pop_front();
                    check("wb_pc", 64'(bus.mem_pc), 64'(mon_e.pc));
                    check("wb_result", 64'(bus.mem_result), 64'(mon_e.result));
                    check("wb_rf_all", 64'(bus.mem_rf_all), 64'(mon_e.rf_all));
                    check("wb_fwd", 64'(bus.mem_fwd_all), 64'({1'b0, mon_e.rf_all, mon_e.result}));
                end
                last_leave = cyc;
            end
            if (pending && bus.data_sram_data_ok) begin
                pending = 1'b0;
                dok_count++;
            end
            if (bus.data_sram_req) begin
                if (exp_req.size() == 0) begin
                    check("spurious_req", 64'd1, 64'd0);
                end else begin
                    mon_r = exp_req[0];
                    check("req_wr", 64'(bus.data_sram_wr), 64'(mon_r.wr));
                    check("req_size", 64'(bus.data_sram_size), 64'(mon_r.size));
                    check("req_wstrb", 64'(bus.data_sram_wstrb), 64'(mon_r.wstrb));
                    check("req_addr", 64'(bus.data_sram_addr), 64'(mon_r.addr));
                    if (mon_r.wr) check("req_wdata", 64'(bus.data_sram_wdata), 64'(mon_r.wdata));
                    if (req_wait == 0) req_gap = cyc - last_leave;
                    if (bus.data_sram_addr_ok) begin
                        void'(exp_req.pop_front());
                        if (mon_r.wr) begin
                            for (int i = 0; i < 4; i++)
                                if (bus.data_sram_wstrb[i])
                                    sram_mem[bus.data_sram_addr[5:2]][8*i +: 8] = bus.data_sram_wdata[8*i +: 8];
                        end else begin
                            rd_word = sram_mem[bus.data_sram_addr[5:2]];
                        end
                        pending  = 1'b1;
                        lat      = (cfg_dok_lat >= 0) ? cfg_dok_lat : int'($urandom_range(0, 3));
                        req_wait = 0;
                    end else begin
                        if (req_wait == 0)
                            need_wait = (cfg_aok_lat >= 0) ? cfg_aok_lat : int'($urandom_range(1, 3));
                        req_wait++;
                    end
                end
            end
        end
    end

    initial begin
        bus.data_sram_addr_ok = 1'b0;
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = 32'd0;
        forever begin
            @(posedge clk); #1;
            if (pending) begin
                bus.data_sram_addr_ok = 1'b0;
                bus.data_sram_data_ok = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                bus.data_sram_data_ok = 1'b0;
                if (req_wait == 0)
                    bus.data_sram_addr_ok = (cfg_aok_lat >= 0) ? (cfg_aok_lat == 0) : 1'($urandom_range(0, 1));
                else
                    bus.data_sram_addr_ok = (req_wait >= need_wait);
            end
            bus.data_sram_rdata = bus.data_sram_data_ok ? rd_word : $urandom;
        end
    end

    initial begin
        bus.wb_allowin = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.wb_allowin = (wb_mode == 0) ? ($urandom_range(0, 3) != 0) : (wb_mode == 1);
        end
    end

    initial begin
        bit   ok;
        int   d0;
        int   k;
        logic [31:0] a;
        bus.exe_to_mem_valid = 1'b0;
        bus.exe_pc = 32'd0; bus.exe_result = 32'd0; bus.exe_res_from_mem = 1'b0;
        bus.exe_mem_all = 8'd0; bus.exe_rkd_value = 32'd0; bus.exe_rf_all = 6'd0;
        for (int i = 0; i < 16; i++) begin
            sram_mem[i] = $urandom;
            for (int j = 0; j < 4; j++) ref_bytes[4*i+j] = sram_mem[i][8*j +: 8];
        end

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_wb_valid", 64'(bus.mem_to_wb_valid), 64'd0);
        check("rst_req", 64'(bus.data_sram_req), 64'd0);
        check("rst_allowin", 64'(bus.mem_allowin), 64'd1);
        check("rst_rf_all", 64'(bus.mem_rf_all), 64'd0);
        check("rst_fwd_flags", 64'(bus.mem_fwd_all[38:37]), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Non-memory op passes through in one cycle.
        wb_mode = 1; cfg_aok_lat = 0; cfg_dok_lat = 0;
        issue(K_ALU, 32'h0000_1234, 32'd0, 32'h100, 1'b1, 5'd5);
        @(negedge clk);
        check("alu_latency", 64'(bus.mem_to_wb_valid), 64'd1);
        check("alu_no_req", 64'(bus.data_sram_req), 64'd0);
        check("alu_result", 64'(bus.mem_result), 64'h1234);
        wait_idle();

        // Byte store with addr_ok held off for three cycles.
        cfg_aok_lat = 3; cfg_dok_lat = 1;
        issue(K_SB, 32'h0000_1002, 32'h0000_00AB, 32'h104, 1'b0, 5'd0);
        @(negedge clk);
        check("sb_wstrb", 64'(bus.data_sram_wstrb), 64'b0100);
        check("sb_wdata", 64'(bus.data_sram_wdata), 64'hABAB_ABAB);
        check("sb_size_wr", 64'({bus.data_sram_size, bus.data_sram_wr}), 64'b001);
        wait_idle();

        // Halfword loads from the upper lane, signed and unsigned.
        sram_mem[0] = 32'h8001_FFFF;
        for (int j = 0; j < 4; j++) ref_bytes[j] = sram_mem[0][8*j +: 8];
        cfg_aok_lat = 0; cfg_dok_lat = 2;
        issue(K_LH, 32'h0000_2002, 32'd0, 32'h108, 1'b1, 5'd6);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.mem_to_wb_valid) ok = 1'b1;
        end
        check("lh_done", 64'(ok), 64'd1);
        check("lh_result", 64'(bus.mem_result), 64'hFFFF_8001);
        check("lh_zero_bubble", 64'(bus.data_sram_data_ok), 64'd1);
        wait_idle();
        issue(K_LHU, 32'h0000_2002, 32'd0, 32'h10C, 1'b1, 5'd6);
        wait_idle();

        // Load-use forwarding flag stays up until data_ok.
        cfg_dok_lat = 3;
        issue(K_LW, 32'h0000_0008, 32'd0, 32'h110, 1'b1, 5'd7);
        ok = 1'b0;
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            if (bus.mem_to_wb_valid) ok = 1'b1;
            else check("lw_load_pending", 64'(bus.mem_fwd_all[38]), 64'd1);
        end
        check("lw_pending_clear", 64'({ok, bus.mem_fwd_all[38]}), 64'b10);
        wait_idle();

        // Write-back stall after data_ok: buffered data, no second request.
        wb_mode = 2; cfg_dok_lat = 1;
        @(posedge clk); #1;
        d0 = dok_count;
        issue(K_LB, 32'h0000_0005, 32'd0, 32'h114, 1'b1, 5'd8);
        for (int n = 0; n < 20 && dok_count == d0; n++) @(negedge clk);
        check("stall_data_ok", 64'(dok_count), 64'(d0 + 1));
        repeat (2) begin
            @(negedge clk);
            check("stall_valid", 64'(bus.mem_to_wb_valid), 64'd1);
            check("stall_no_req", 64'(bus.data_sram_req), 64'd0);
        end
        wb_mode = 1;
        wait_idle();

        // Back-to-back: next request the cycle after the load leaves.
        cfg_dok_lat = 2;
        issue(K_LB, 32'h0000_0003, 32'd0, 32'h118, 1'b1, 5'd9);
        issue(K_SW, 32'h0000_0010, $urandom, 32'h11C, 1'b0, 5'd0);
        wait_idle();
        check("b2b_req_gap", 64'(req_gap), 64'd1);

        // Reset while waiting for data_ok.
        cfg_dok_lat = 5;
        issue(K_LW, 32'h0000_0020, 32'd0, 32'h120, 1'b1, 5'd10);
        for (int n = 0; n < 20 && !pending; n++) @(negedge clk);
        check("rst_wait_reached", 64'(pending), 64'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_wb.delete();
        exp_req.delete();
        @(negedge clk);
        check("midrst_wb_valid", 64'(bus.mem_to_wb_valid), 64'd0);
        check("midrst_req", 64'(bus.data_sram_req), 64'd0);
        check("midrst_allowin", 64'(bus.mem_allowin), 64'd1);
        @(posedge clk); #1;

        // Randomised traffic with random SRAM latency and write-back back-pressure.
        cfg_aok_lat = -1; cfg_dok_lat = -1; wb_mode = 0;
        for (int i = 0; i < 300; i++) begin
            k = int'($urandom_range(0, 8));
            a = $urandom;
            if (k == K_LH || k == K_LHU || k == K_SH) a[0] = 1'b0;
            if (k == K_LW || k == K_SW) a[1:0] = 2'b00;
            issue(k, a, $urandom, $urandom, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk); #1;
            end
        end
        wb_mode = 1;
        wait_idle();
        check("final_req_queue", 64'(exp_req.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage. Sits directly downstream of the execute stage and upstream of write-back.
- Latches the execute-stage payload and issues at most one data-SRAM request per instruction over an SRAM-like req/addr_ok/data_ok interface.
- Aligns store data and byte strobes, extracts and extends load data, and presents the write-back payload and a forwarding bus to the decode stage.
- Non-memory instructions pass through in one cycle.

Parameters:
- None. Widths are fixed: 32-bit data/address, 5-bit register address.

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous active-high reset
exe_to_mem_valid  in  1  execute stage offers an instruction
mem_allowin  out  1  stage can accept this cycle
exe_pc  in  32  instruction PC
exe_result  in  32  ALU/mul/div result; effective address for loads/stores
exe_res_from_mem  in  1  instruction is a load
exe_mem_all  in  8  {mem_we, ld_b, ld_h, ld_w, ld_se, st_b, st_h, st_w}
exe_rkd_value  in  32  store source data
exe_rf_all  in  6  {rf_we, rf_waddr[4:0]}
data_sram_req  out  1  request valid
data_sram_wr  out  1  1 = store
data_sram_size  out  2  0 byte, 1 half, 2 word
data_sram_wstrb  out  4  byte enables (0 for loads)
data_sram_addr  out  32  byte address
data_sram_wdata  out  32  lane-replicated store data
data_sram_addr_ok  in  1  request accepted
data_sram_data_ok  in  1  response/write-ack
data_sram_rdata  in  32  read data, valid with data_ok
wb_allowin  in  1  write-back can accept
mem_to_wb_valid  out  1  payload valid to write-back
mem_pc  out  32  latched PC
mem_result  out  32  final result
mem_rf_all  out  6  {rf_we & mem_valid, rf_waddr}
mem_fwd_all  out  39  {mem_load_pending, rf_we & mem_valid, rf_waddr, mem_result}

Behaviour:
- Handshake:
  - mem_allowin = ~mem_valid | (mem_ready_go & wb_allowin).
  - On mem_allowin, mem_valid <= exe_to_mem_valid.
  - Payload latched only when exe_to_mem_valid & mem_allowin.
  - mem_to_wb_valid = mem_valid & mem_ready_go.
- Reset values: mem_valid 0, state IDLE, mem_rf_all 0, data_sram_req 0, rdata buffer 0. Other latched payload registers are don't-care when not valid.
- Memory instruction: is_mem = mem_we | exe_res_from_mem. Not gated further.
- FSM states: IDLE, REQ, WAIT, DONE.
  - On payload latch: next state REQ if the incoming instruction is_mem, else IDLE. This applies also when the latch coincides with the current instruction leaving the stage.
  - REQ: data_sram_req=1 with all request fields stable and derived from latched payload. addr_ok -> WAIT.
  - WAIT: data_ok -> DONE; rdata captured into buffer.
  - DONE: hold until the instruction leaves the stage.
  - data_ok is ignored outside WAIT. data_ok never coincides with addr_ok for the same request.
- mem_ready_go = (state==IDLE) | (state==DONE) | (state==WAIT & data_ok).
  - In the WAIT & data_ok case, data_sram_rdata is used directly (zero-bubble).
  - A stalled DONE uses the buffered rdata.
- data_sram_req = mem_valid & (state==REQ). Exactly one request per memory instruction. No request for non-memory instructions or bubbles.
- Size: st_b|ld_b -> 0; st_h|ld_h -> 1; otherwise 2.
- Store strobes, a = addr[1:0]:
  - byte: 4'b0001 << a
  - half: 4'b0011 << {a[1],1'b0}
  - word: 4'b1111
- wdata: byte {4{rkd[7:0]}}; half {2{rkd[15:0]}}; word rkd.
- Address alignment is guaranteed upstream. Misaligned low bits are used only for lane select.
- Load extraction:
  - byte: lane rdata[8a+7:8a].
  - half: rdata[31:16] if a[1], else rdata[15:0].
  - Sign-extend if ld_se, else zero-extend. Word is passed unchanged.
- mem_result = res_from_mem ? load_data : exe_result.
- mem_load_pending = mem_valid & res_from_mem & ~mem_ready_go. Decode stalls on a matching waddr while this is set.
- Write-back stall: a DONE instruction holds all outputs and issues no new request.
- Reset mid-transaction: FSM returns to IDLE and mem_valid clears. The SRAM side is reset on the same edge, so a late data_ok is never seen.

Test Plan:
- ALU op exe_result=0x1234, wb_allowin=1 -> mem_to_wb_valid next cycle, mem_result=0x1234, no data_sram_req.
- st.b rkd=0x000000AB, addr 0x1002 -> req with wr=1, size=0, wstrb=4'b0100, wdata=0xABABABAB. addr_ok held low 3 cycles -> req and fields stay stable. Ready_go only after data_ok.
- ld.h signed addr 0x2002, rdata=0x8001FFFF on data_ok -> mem_result=0xFFFF8001 in the same cycle. ld.hu -> 0x00008001.
- ld.w followed by dependent decode: mem_fwd_all[38]=1 until data_ok. Clears with mem_result=rdata in the data_ok cycle.
- Load completes while wb_allowin=0 for 2 cycles -> state DONE, buffered rdata held, no second request. Leaves when wb_allowin=1.
- Back-to-back ld.b (addr 0x3) then st.w -> second request issued the cycle after the first instruction leaves. Reset asserted while in WAIT -> mem_valid=0, req=0 next cycle.
